// File: rtl/i8251_pkg.sv
// i8251 shared definitions.
// Used by the receiver, the transmitter and the future i8251 top level.
//   rx_state_t      : receiver state encoding
//   BAUD_*          : mode-register baud_rate field codes
//   CHAR_LEN_*      : mode-register char_len field codes
//   baud_divider()  : clock divider N (1/16/64) selected by baud_rate
//   align_char()    : right-aligns an LSB-first shift register holding char_len+5 bits
`timescale 1ns/1ps
package i8251_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] BAUD_SYNC = 2'd0;
    localparam logic [1:0] BAUD_X1   = 2'd1;
    localparam logic [1:0] BAUD_X16  = 2'd2;
    localparam logic [1:0] BAUD_X64  = 2'd3;

    localparam logic [1:0] CHAR_LEN_5 = 2'd0;
    localparam logic [1:0] CHAR_LEN_6 = 2'd1;
    localparam logic [1:0] CHAR_LEN_7 = 2'd2;
    localparam logic [1:0] CHAR_LEN_8 = 2'd3;

    // Sync mode has no async divider; it reports 1 so that counter
    // arithmetic stays well defined while the receiver is held idle.
    function automatic logic [6:0] baud_divider(input logic [1:0] baud_rate);
        logic [6:0] n;
        case (baud_rate)
            BAUD_X16: n = 7'd16;
            BAUD_X64: n = 7'd64;
            default:  n = 7'd1;
        endcase
        return n;
    endfunction

    // Bits arrive LSB first and are shifted in at bit 7, so a short
    // character sits in the top bits; shifting right zero-fills the rest.
    function automatic logic [7:0] align_char(input logic [7:0] shift,
                                              input logic [1:0] char_len);
        return shift >> (CHAR_LEN_8 - char_len);
    endfunction

endpackage

// File: rtl/i8251_rx_sampler.sv
// i8251 receiver front end: RxD synchroniser and bit-timing counter.
//   clk21m, reset    : system clock, asynchronous active-high reset
//   ireset_i         : synchronous internal reset (clears the counter)
//   rxc_en_i         : one-cycle pulse per receiver clock tick
//   rxd_i            : raw asynchronous serial input
//   baud_rate_i      : mode field selecting divider N
//   cnt_clr_i        : hold the counter at zero (receiver idle)
//   half_bit_i       : time half a bit (start-bit centre) instead of a full bit
//   rxd_sync_o       : rxd after the 2-flop synchroniser
//   sample_o         : tick on which the current bit is at its centre
`timescale 1ns/1ps
module i8251_rx_sampler
    import i8251_pkg::*;
(
    input  logic       clk21m,
    input  logic       reset,
    input  logic       ireset_i,
    input  logic       rxc_en_i,
    input  logic       rxd_i,
    input  logic [1:0] baud_rate_i,
    input  logic       cnt_clr_i,
    input  logic       half_bit_i,
    output logic       rxd_sync_o,
    output logic       sample_o
);

    logic [1:0] sync_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic [5:0] target;
    logic [6:0] div;

    // The counter restarts at zero on the sampling tick, so the next bit
    // centre falls exactly N ticks later.  For N=1 the target is 0 and
    // every tick samples.
    always_comb begin
        div = baud_divider(baud_rate_i);
        if (half_bit_i) begin
            target = 6'((div >> 1) - 7'd1);
        end else begin
            target = 6'(div - 7'd1);
        end
        sample_o = rxc_en_i && (cnt_q == target);
        cnt_d    = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = 6'd0;
        end else if (rxc_en_i) begin
            cnt_d = (cnt_q == target) ? 6'd0 : cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= 6'd0;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            cnt_q  <= ireset_i ? 6'd0 : cnt_d;
        end
    end

    assign rxd_sync_o = sync_q[1];

endmodule

// File: rtl/i8251_receiver.sv
// i8251 USART asynchronous receiver.
// Deserialises rxd into q, raises rxrdy, and keeps sticky parity,
// overrun and framing flags for the status register.
//   reset, clk21m    : asynchronous active-high reset, system clock
//   rxc_en           : one-cycle pulse per RxC rising edge
//   rd, a            : CPU read strobe (level) and register select (0 = data)
//   rxd              : serial input, idle high
//   ireset           : synchronous internal reset from the command register
//   rx_enable        : command RxE
//   error_reset      : command ER, clears all error flags while high
//   stop_bits, even_parity, parity_en, char_len, baud_rate : mode fields
//   q                : received character, upper bits zero
//   rxrdy            : character available
//   parity_error, overrun_error, framing_error : sticky status flags
`timescale 1ns/1ps
module i8251_receiver
    import i8251_pkg::*;
(
    input  logic       reset,
    input  logic       clk21m,
    input  logic       rxc_en,
    input  logic       rd,
    input  logic       a,
    input  logic       rxd,
    input  logic       ireset,
    input  logic       rx_enable,
    input  logic       error_reset,
    input  logic [1:0] stop_bits,
    input  logic       even_parity,
    input  logic       parity_en,
    input  logic [1:0] char_len,
    input  logic [1:0] baud_rate,
    output logic [7:0] q,
    output logic       rxrdy,
    output logic       parity_error,
    output logic       overrun_error,
    output logic       framing_error
);

    rx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       perr_pend_q, perr_pend_d;
    logic       brk_q, brk_d;
    logic [7:0] q_q, q_d;
    logic       rxrdy_q, rxrdy_d;
    logic       perr_q, perr_d;
    logic       oerr_q, oerr_d;
    logic       ferr_q, ferr_d;
    logic       rd_prev_q, rd_clr_q;

    logic       rxd_s;
    logic       sample;
    logic       cnt_clr;
    logic       half_bit;
    logic       en;
    logic       last_bit;
    logic       load;
    logic       stop_bad;
    logic       par_calc;
    logic       rd_lvl;
    logic [7:0] aligned;

    // Only the first stop bit is checked; extra stop time looks like idle.
    logic       unused_stop_bits;
    assign unused_stop_bits = ^stop_bits;

    i8251_rx_sampler u_sampler (
        .clk21m      (clk21m),
        .reset       (reset),
        .ireset_i    (ireset),
        .rxc_en_i    (rxc_en),
        .rxd_i       (rxd),
        .baud_rate_i (baud_rate),
        .cnt_clr_i   (cnt_clr),
        .half_bit_i  (half_bit),
        .rxd_sync_o  (rxd_s),
        .sample_o    (sample)
    );

    assign en       = rx_enable && (baud_rate != BAUD_SYNC);
    assign last_bit = (bit_cnt_q == (3'(char_len) + 3'd4));
    assign aligned  = align_char(shift_q, char_len);
    assign par_calc = (^aligned) ^ rxd_s;
    assign rd_lvl   = rd & ~a;

    // Next-state logic for the bit-level FSM.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        perr_pend_d = perr_pend_q;
        brk_d       = brk_q;
        load        = 1'b0;
        stop_bad    = 1'b0;
        cnt_clr     = 1'b0;
        half_bit    = (state_q == RX_START);

        // A break only ends once the line has been seen high.
        if (rxc_en && rxd_s) begin
            brk_d = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                cnt_clr     = 1'b1;
                bit_cnt_d   = 3'd0;
                perr_pend_d = 1'b0;
                if (rxc_en && !rxd_s && !brk_q) begin
                    // At x1 there is no mid-bit to wait for.
                    state_d = (baud_rate == BAUD_X1) ? RX_DATA : RX_START;
                end
            end
            RX_START: begin
                if (sample) begin
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = parity_en ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (sample) begin
                    perr_pend_d = (par_calc != (even_parity ? 1'b0 : 1'b1));
                    state_d     = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample) begin
                    load     = 1'b1;
                    stop_bad = ~rxd_s;
                    if (!rxd_s) begin
                        brk_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        if (!en) begin
            state_d  = RX_IDLE;
            load     = 1'b0;
            stop_bad = 1'b0;
            cnt_clr  = 1'b1;
            brk_d    = brk_q && !(rxc_en && rxd_s);
        end
    end

    // Character and status registers.  A read clears rxrdy one cycle after
    // the strobe rises; a load in that same cycle wins and is not an overrun.
    always_comb begin
        q_d     = q_q;
        rxrdy_d = rxrdy_q;
        perr_d  = perr_q;
        oerr_d  = oerr_q;
        ferr_d  = ferr_q;
        if (rd_clr_q) begin
            rxrdy_d = 1'b0;
        end
        if (load) begin
            q_d     = aligned;
            rxrdy_d = 1'b1;
            if (perr_pend_q) begin
                perr_d = 1'b1;
            end
            if (stop_bad) begin
                ferr_d = 1'b1;
            end
            if (rxrdy_q && !rd_clr_q) begin
                oerr_d = 1'b1;
            end
        end
        if (error_reset) begin
            perr_d = 1'b0;
            oerr_d = 1'b0;
            ferr_d = 1'b0;
        end
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            perr_pend_q <= 1'b0;
            brk_q       <= 1'b0;
            q_q         <= 8'h00;
            rxrdy_q     <= 1'b0;
            perr_q      <= 1'b0;
            oerr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            rd_prev_q   <= 1'b0;
            rd_clr_q    <= 1'b0;
        end else if (ireset) begin
            state_q     <= RX_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            perr_pend_q <= 1'b0;
            brk_q       <= 1'b0;
            q_q         <= 8'h00;
            rxrdy_q     <= 1'b0;
            perr_q      <= 1'b0;
            oerr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            rd_prev_q   <= 1'b0;
            rd_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            perr_pend_q <= perr_pend_d;
            brk_q       <= brk_d;
            q_q         <= q_d;
            rxrdy_q     <= rxrdy_d;
            perr_q      <= perr_d;
            oerr_q      <= oerr_d;
            ferr_q      <= ferr_d;
            rd_prev_q   <= rd_lvl;
            rd_clr_q    <= rd_lvl & ~rd_prev_q;
        end
    end

    assign q             = q_q;
    assign rxrdy         = rxrdy_q;
    assign parity_error  = perr_q;
    assign overrun_error = oerr_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_i8251_receiver.sv
// Testbench for i8251_receiver: directed serial frames, expected loads
// queued by the stimulus and checked by a monitor on each rxrdy rise.
`timescale 1ns/1ps
module tb_i8251_receiver;

    logic       reset, clk21m, rxc_en, rd, a, rxd, ireset, rx_enable, error_reset;
    logic [1:0] stop_bits, char_len, baud_rate;
    logic       even_parity, parity_en;
    logic [7:0] q;
    logic       rxrdy, parity_error, overrun_error, framing_error;

    typedef struct packed {
        logic [7:0] q;
        logic       pe;
        logic       oe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   tick_cnt     = 0;
    int   rise_tick    = 0;
    int   rise_cnt     = 0;
    int   frame_start  = 0;
    logic mon_prev     = 1'b0;

    i8251_receiver dut (
        .reset         (reset),
        .clk21m        (clk21m),
        .rxc_en        (rxc_en),
        .rd            (rd),
        .a             (a),
        .rxd           (rxd),
        .ireset        (ireset),
        .rx_enable     (rx_enable),
        .error_reset   (error_reset),
        .stop_bits     (stop_bits),
        .even_parity   (even_parity),
        .parity_en     (parity_en),
        .char_len      (char_len),
        .baud_rate     (baud_rate),
        .q             (q),
        .rxrdy         (rxrdy),
        .parity_error  (parity_error),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial begin
        clk21m = 1'b0;
        forever #5 clk21m = ~clk21m;
    end

    // RxC tick on every other clk21m cycle.
    initial begin
        rxc_en = 1'b0;
        forever begin
            @(negedge clk21m);
            rxc_en = ~rxc_en;
        end
    end

    always @(posedge clk21m) begin
        if (rxc_en) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every new character (rxrdy rising) must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk21m);
            if (rxrdy === 1'b1 && mon_prev !== 1'b1) begin
                rise_cnt++;
                rise_tick = tick_cnt;
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_load: got q=0x%0h, expected no character", q);
                end else begin
                    e = sb.pop_front();
                    check("load_q",  32'(q),             32'(e.q));
                    check("load_pe", 32'(parity_error),  32'(e.pe));
                    check("load_oe", 32'(overrun_error), 32'(e.oe));
                    check("load_fe", 32'(framing_error), 32'(e.fe));
                end
            end
            mon_prev = rxrdy;
        end
    end

    function automatic int div_of(input logic [1:0] b);
        case (b)
            2'd2:    return 16;
            2'd3:    return 64;
            default: return 1;
        endcase
    endfunction

    task automatic tick();
        do @(posedge clk21m); while (rxc_en !== 1'b1);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (div_of(baud_rate)) tick();
    endtask

    task automatic push_exp(input logic [7:0] eq, input logic pe, input logic oe, input logic fe);
        exp_t e;
        e.q = eq; e.pe = pe; e.oe = oe; e.fe = fe;
        sb.push_back(e);
    endtask

    // Transmitter model: start, char_len+5 data bits LSB first, optional
    // parity, one stop bit, then the remaining stop time and a short idle.
    task automatic send_frame(input logic [7:0] data, input logic par_ok, input logic stop_v);
        int   nb;
        logic p;
        nb = int'(char_len) + 5;
        tick();
        rxd = 1'b0;
        frame_start = tick_cnt;
        repeat (div_of(baud_rate)) tick();
        for (int i = 0; i < nb; i++) send_bit(data[i]);
        if (parity_en) begin
            p = 1'b0;
            for (int i = 0; i < nb; i++) p ^= data[i];
            if (!even_parity) p = ~p;
            if (!par_ok) p = ~p;
            send_bit(p);
        end
        send_bit(stop_v);
        if (stop_v) begin
            if (stop_bits == 2'd2) repeat (div_of(baud_rate) / 2) tick();
            else if (stop_bits == 2'd3) repeat (div_of(baud_rate)) tick();
            repeat (4) tick();
        end
    endtask

    task automatic cpu_read(input logic sel);
        @(negedge clk21m);
        a  = sel;
        rd = 1'b1;
        repeat (3) @(negedge clk21m);
        rd = 1'b0;
        a  = 1'b0;
        repeat (2) @(negedge clk21m);
    endtask

    task automatic pulse_error_reset();
        @(negedge clk21m);
        error_reset = 1'b1;
        @(negedge clk21m);
        error_reset = 1'b0;
        @(negedge clk21m);
    endtask

    logic [7:0] exp_aa [4];
    int         rc;

    initial begin
        exp_aa = '{8'h0A, 8'h2A, 8'h2A, 8'hAA};
        reset = 1'b1; rd = 1'b0; a = 1'b0; rxd = 1'b1; ireset = 1'b0;
        rx_enable = 1'b1; error_reset = 1'b0; stop_bits = 2'd1;
        even_parity = 1'b0; parity_en = 1'b0; char_len = 2'd3; baud_rate = 2'd2;
        repeat (3) @(negedge clk21m);
        check("reset_q",     32'(q),             32'h00);
        check("reset_rxrdy", 32'(rxrdy),         32'h0);
        check("reset_pe",    32'(parity_error),  32'h0);
        check("reset_oe",    32'(overrun_error), 32'h0);
        check("reset_fe",    32'(framing_error), 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk21m);

        // 1: x16 8N1 0x55; stop centre is 9.5 bits = 152 ticks after the
        // edge, plus 2 ticks of synchroniser latency.
        push_exp(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1);
        check("t1_latency_ticks", 32'(rise_tick - frame_start), 32'd154);
        cpu_read(1'b1);
        check("t1_rxrdy_after_status_read", 32'(rxrdy), 32'h1);
        cpu_read(1'b0);
        check("t1_rxrdy_after_data_read", 32'(rxrdy), 32'h0);
        check("t1_q_held", 32'(q), 32'h55);

        // 2: x1, 8 bits, odd parity 0xAA (parity bit 1 correct, 0 wrong).
        baud_rate = 2'd1; parity_en = 1'b1; even_parity = 1'b0;
        push_exp(8'hAA, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1);
        cpu_read(1'b0);
        push_exp(8'hAA, 1'b1, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1);
        cpu_read(1'b0);
        check("t2_pe_sticky", 32'(parity_error), 32'h1);
        pulse_error_reset();
        check("t2_pe_cleared", 32'(parity_error), 32'h0);

        // 3: x64, 5 bits, no parity; then a framing error that becomes a break.
        baud_rate = 2'd3; char_len = 2'd0; parity_en = 1'b0;
        push_exp(8'h0A, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b1);
        cpu_read(1'b0);
        push_exp(8'h0A, 1'b0, 1'b0, 1'b1);
        rc = rise_cnt;
        send_frame(8'hAA, 1'b1, 1'b0);
        repeat (3 * 7 * 64) tick();
        check("t3_break_one_char", 32'(rise_cnt - rc), 32'd1);
        check("t3_fe_set", 32'(framing_error), 32'h1);
        rxd = 1'b1;
        repeat (128) tick();
        cpu_read(1'b0);
        check("t3_rxrdy_cleared", 32'(rxrdy), 32'h0);
        push_exp(8'h0A, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        cpu_read(1'b0);
        pulse_error_reset();
        check("t3_fe_cleared", 32'(framing_error), 32'h0);

        // 4: x16 8N1, two characters without a read -> overrun.
        baud_rate = 2'd2; char_len = 2'd3;
        push_exp(8'h31, 1'b0, 1'b0, 1'b0);
        rc = rise_cnt;
        send_frame(8'h31, 1'b1, 1'b1);
        send_frame(8'h32, 1'b1, 1'b1);
        check("t4_single_rise", 32'(rise_cnt - rc), 32'd1);
        check("t4_q",     32'(q),             32'h32);
        check("t4_rxrdy", 32'(rxrdy),         32'h1);
        check("t4_oe",    32'(overrun_error), 32'h1);
        cpu_read(1'b0);
        pulse_error_reset();
        check("t4_oe_cleared", 32'(overrun_error), 32'h0);

        // 5: 3-tick glitch is a false start; reset mid-DATA clears everything.
        rc = rise_cnt;
        tick();
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (40) tick();
        check("t5_glitch_no_load", 32'(rise_cnt - rc), 32'd0);
        check("t5_glitch_rxrdy",   32'(rxrdy),         32'h0);
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk21m);
        reset = 1'b1;
        #1;
        check("t5_reset_q",     32'(q),     32'h00);
        check("t5_reset_rxrdy", 32'(rxrdy), 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk21m);
        reset = 1'b0;
        repeat (40) tick();
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1);
        cpu_read(1'b0);

        // 6: transmitter loopback model, every char_len x parity combination.
        for (int cl = 0; cl < 4; cl++) begin
            for (int pm = 0; pm < 3; pm++) begin
                char_len    = 2'(cl);
                parity_en   = (pm != 0);
                even_parity = (pm == 2);
                stop_bits   = 2'(1 + ((cl + pm) % 3));
                push_exp(exp_aa[cl], 1'b0, 1'b0, 1'b0);
                send_frame(8'hAA, 1'b1, 1'b1);
                cpu_read(1'b0);
            end
        end

        repeat (20) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i8251_receiver.md
Name: i8251_receiver

Overview:
Asynchronous serial receiver for the i8251 USART: deserialises RxD into a character register and sets RxRDY.
Pairs with i8251_transmitter (its txd can loop back to rxd) and shares the same mode fields and CPU bus strobes.
Reports parity, overrun and framing errors for the status register.
Synchronous mode (baud_rate=0) is not supported: the receiver stays idle.

Parameters:
none (all configuration comes from mode inputs)

Ports:
reset  in  1  asynchronous, active-high
clk21m  in  1  system clock
rxc_en  in  1  one-clk21m-cycle pulse per receiver clock (RxC) rising edge
rd  in  1  CPU read strobe, level, may last several cycles
a  in  1  register select; 0 = data
rxd  in  1  serial input, asynchronous, idle high
ireset  in  1  internal reset from command register
rx_enable  in  1  command RxE bit
error_reset  in  1  command ER bit, level
stop_bits  in  2  mode: 1 = 1 bit, 2 = 1.5 bits, 3 = 2 bits (receiver checks the first only)
even_parity  in  1  1 = even, 0 = odd
parity_en  in  1  parity bit present
char_len  in  2  0/1/2/3 = 5/6/7/8 bits
baud_rate  in  2  0 = sync (idle), 1 = x1, 2 = x16, 3 = x64
q  out  8  received character; unused upper bits are 0
rxrdy  out  1  character available
parity_error  out  1  sticky
overrun_error  out  1  sticky
framing_error  out  1  sticky

Behaviour:
- Reset or ireset: state IDLE, q=0x00, rxrdy=0, all errors=0, counters=0. ireset is synchronous; reset is asynchronous.
- rxd passes a 2-flop synchroniser in clk21m. The state machine advances only on cycles where rxc_en=1.
- Divider N: 1, 16 or 64 from baud_rate. Sample counter is 6 bits and wraps at N.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxd=0 is sampled, go to START and clear the counter. If N=1, the start is accepted immediately and the next tick is data bit 0.
- START (N>1): at tick N/2 (mid-bit), re-sample.
  - rxd=1: false start, return to IDLE.
  - rxd=0: clear the counter and go to DATA.
- DATA: sample every N ticks at bit centre, LSB first, into a shift register. Take char_len+5 bits, then go to PARITY if parity_en, else STOP.
- PARITY: sample 1 bit. Error if XOR(data bits, parity bit) differs from even_parity?0:1.
- STOP: sample 1 bit. On that same tick:
  - load q, with upper bits zero-filled;
  - set rxrdy;
  - set parity_error if mismatched;
  - set framing_error if the stop bit sampled 0;
  - set overrun_error if rxrdy was already 1 (the new char overwrites q);
  - return to IDLE. Extra stop bits are not checked; a new start bit is accepted from the next tick.
- Framing error with rxd=0 at stop: IDLE must not re-trigger until rxd has been sampled 1 at least once. A break therefore produces exactly one character.
- Read: the rising edge of (rd & ~a) clears rxrdy one clk21m cycle later. q is unaffected and holds until the next load.
- Load and read-clear in the same cycle: load wins, rxrdy=1, overrun not set.
- error_reset=1: clears all three error flags every cycle it is high. A simultaneous error set loses to the clear.
- rx_enable=0 or baud_rate=0: force IDLE and block loads. rxrdy and errors hold, and remain clearable.
- Mode inputs are sampled live. Changing them mid-character is undefined, but the design must return to IDLE within one character time.

Decomposition:
- i8251_pkg:
  - state encoding;
  - baud_rate codes (BAUD_SYNC/X1/X16/X64);
  - char_len codes;
  - function giving the divider from baud_rate.
- Shared by i8251_transmitter and a future i8251 top.
- One natural sub-module: i8251_rx_sampler, covering the synchroniser, divider counter and mid-bit sample strobe.

Test Plan:
1. x16, 8N1, rxd frame for 0x55 -> rxrdy=1 at the stop-bit centre (start edge + 9.5 bit times ±1 tick), q=0x55, no errors. Then rd, a=0 -> rxrdy=0.
2. x1, 8-bit, odd parity, send 0xAA with correct parity bit=1, then with wrong parity bit=0 -> first: parity_error=0; second: parity_error=1, q=0xAA. error_reset -> parity_error=0.
3. x64, 5-bit, no parity, send 0xAA low bits (0x0A) -> q=0x0A. Then stop bit forced 0 -> framing_error=1; no retrigger until rxd returns high.
4. x16, two 0x31/0x32 frames without an intervening read -> rxrdy=1, q=0x32, overrun_error=1.
5. x16, 3-tick low glitch on idle rxd -> stays IDLE, rxrdy=0. Also: reset asserted mid-DATA -> all outputs 0, next clean frame (0xA5) received correctly.
6. Loopback from i8251_transmitter txd, all 12 transmitter mode combos, 0xAA -> q equals 0xAA masked to char_len, no errors.
